// File: rtl/mux_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scan_pkg : shared constants and state encoding for mux_scanner        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package mux_scan_pkg;

  localparam int NUM_CH = 6;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/mux_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scanner_if : tagged-sample valid/ready stream out of the scanner      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface mux_scanner_if;
  import mux_scan_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_ch;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/mux_scanner_next_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_next_ch : finds next higher and lowest enabled channel in a mask     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_cur_ch,
  output logic [SEL_W-1:0]  o_next_ch,
  output logic              o_found,
  output logic [SEL_W-1:0]  o_lowest_ch
);

  // Walk downward so the last hit is the smallest qualifying index.
  always_comb begin
    o_next_ch   = '0;
    o_found     = 1'b0;
    o_lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_lowest_ch = SEL_W'(i);
        if (i > int'(i_cur_ch)) begin
          o_next_ch = SEL_W'(i);
          o_found   = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scanner : steps the 6:1 mux select, settles, samples, streams out    |
// | Optional MUX_SCAN_CONTINUOUS_EN: wrap to lowest channel until stop.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mux_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  input  logic [DATA_W-1:0]  mux_data,
  output logic               busy,
  output logic               frame_done,
  mux_scanner_if.master      out_if
);

  localparam logic [1:0] c_IDLE    = ST_IDLE;
  localparam logic [1:0] c_SETTLE  = ST_SETTLE;
  localparam logic [1:0] c_CAPTURE = ST_CAPTURE;

`ifdef MUX_SCAN_CONTINUOUS_EN
  localparam logic c_CONTINUOUS = 1'b1;
`else
  localparam logic c_CONTINUOUS = 1'b0;
`endif

  logic [1:0]         r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ch;
  logic [DATA_W-1:0]  r_data;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell;
  logic [NUM_CH-1:0]  r_mask;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic [NUM_CH-1:0]  w_mask;
  logic [SEL_W-1:0]   w_next_ch;
  logic [SEL_W-1:0]   w_lowest_ch;
  logic               w_found;
  logic               w_any;
  logic               w_accept;

  // In IDLE the finder looks at the live mask to pick the first channel;
  // once a frame runs only the latched copy matters.
  assign w_mask   = (r_state == c_IDLE) ? ch_mask : r_mask;
  assign w_any    = |w_mask;
  assign w_accept = r_valid & out_if.out_ready;

  scan_next_ch u_next_ch (
    .i_mask      (w_mask),
    .i_cur_ch    (r_sel),
    .o_next_ch   (w_next_ch),
    .o_found     (w_found),
    .o_lowest_ch (w_lowest_ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_sel   <= '0;
      r_ch    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_dwell <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start && !stop && w_any) begin
            r_state <= c_SETTLE;
            r_sel   <= w_lowest_ch;
            r_mask  <= ch_mask;
            r_dwell <= dwell;
            r_cnt   <= dwell;
            r_busy  <= 1'b1;
          end
        end

        c_SETTLE: begin
          if (stop) begin
            r_state <= c_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= c_CAPTURE;
            r_valid <= 1'b1;
            r_data  <= mux_data;
            r_ch    <= r_sel;
          end else begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end
        end

        c_CAPTURE: begin
          // stop is only honoured once the offered sample has been taken.
          if (w_accept) begin
            r_valid <= 1'b0;
            if (w_found && !stop) begin
              r_state <= c_SETTLE;
              r_sel   <= w_next_ch;
              r_cnt   <= r_dwell;
            end else if (c_CONTINUOUS && !stop) begin
              r_state <= c_SETTLE;
              r_sel   <= w_lowest_ch;
              r_cnt   <= r_dwell;
              r_done  <= 1'b1;
            end else begin
              r_state <= c_IDLE;
              r_sel   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= c_IDLE;
          r_sel   <= '0;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel              = r_sel;
  assign busy             = r_busy;
  assign frame_done       = r_done;
  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_data;
  assign out_if.out_ch    = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mux_scanner : randomized frames against a timing/ordering model        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_mux_scanner;
  import mux_scan_pkg::*;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              start   = 1'b0;
  logic              stop    = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [7:0]        dwell   = '0;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_data;
  logic              busy;
  logic              frame_done;

  logic [DATA_W-1:0] tab [0:7];
  int unsigned       cyc      = 0;
  int                checks   = 0;
  int                failures = 0;

  mux_scanner_if u_if ();

  mux_scanner #(.DWELL_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .sel        (sel),
    .mux_data   (mux_data),
    .busy       (busy),
    .frame_done (frame_done),
    .out_if     (u_if)
  );

  // Mux model: output is a per-frame random table indexed by select.
  assign mux_data = tab[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n) chk("sel_range", 32'(int'(sel) < NUM_CH), 1);

  task automatic wait_valid(input int unsigned limit);
    while (!u_if.out_valid && cyc < limit) @(negedge clk);
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen = seen | u_if.out_valid | frame_done;
    end
    chk(tag, seen, 0);
  endtask

  // One frame: expected samples are the enabled channels in ascending order;
  // each sample appears dwell+1 edges after the edge that launched its channel.
  task automatic do_frame(input logic [NUM_CH-1:0] mask, input int d,
                          input int hold_ch, input int hold_len, input int max_hold);
    int          q[$];
    int unsigned a_edge, due;
    int          hold;
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) q.push_back(i);
    for (int i = 0; i < 8; i++) tab[i] = 4'($urandom);
    @(negedge clk);
    ch_mask = mask; dwell = 8'(d); start = 1'b1;
    a_edge  = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_sel", sel, q[0]);
    chk("start_valid", u_if.out_valid, 0);
    ch_mask = 6'($urandom); dwell = 8'($urandom);
    foreach (q[j]) begin
      due = a_edge + 32'(d) + 1;
      while (!u_if.out_valid && cyc < due + 4) begin
        u_if.out_ready = 1'($urandom);
        start          = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      chk("valid_time", cyc, due);
      chk("sample_ch", u_if.out_ch, q[j]);
      chk("sample_data", u_if.out_data, tab[q[j]]);
      chk("sel_at_sample", sel, q[j]);
      chk("no_early_done", frame_done, 0);
      hold = (q[j] == hold_ch) ? hold_len : $urandom_range(0, max_hold);
      u_if.out_ready = 1'b0;
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        chk("stall_valid", u_if.out_valid, 1);
        chk("stall_ch", u_if.out_ch, q[j]);
        chk("stall_data", u_if.out_data, tab[q[j]]);
        chk("stall_sel", sel, q[j]);
      end
      u_if.out_ready = 1'b1;
`ifdef MUX_SCAN_CONTINUOUS_EN
      if (j == q.size() - 1) stop = 1'b1;
`endif
      a_edge = cyc + 1;
      @(negedge clk);
      u_if.out_ready = 1'b0;
      stop           = 1'b0;
      chk("valid_fall", u_if.out_valid, 0);
      if (j < q.size() - 1) chk("next_sel", sel, q[j+1]);
    end
    chk("frame_done", frame_done, 1);
    chk("end_sel", sel, 0);
    @(negedge clk);
    chk("done_pulse", frame_done, 0);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tab[i] = 4'(i + 1);
    repeat (2) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_data", u_if.out_data, 0);
    chk("rst_ch", u_if.out_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    ch_mask = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mask0_busy", busy, 0);
    quiet("mask0_quiet", 4);

    ch_mask = 6'h3F; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_sel", sel, 0);

    do_frame(6'b111111, 0, -1, 0, 0);
    do_frame(6'b100101, 3, -1, 0, 0);
    do_frame(6'b111111, 1, 2, 4, 0);
    for (int n = 0; n < 8; n++)
      do_frame(6'($urandom_range(1, 63)), $urandom_range(0, 6), -1, 0, 2);

    // stop while settling on channel 3
    ch_mask = 6'b001000; dwell = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ss_sel", sel, 3);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_sel_idle", sel, 0);
    chk("ss_valid", u_if.out_valid, 0);
    chk("ss_done", frame_done, 0);
    quiet("ss_quiet", 10);

    // stop while a sample is pending
    ch_mask = 6'b000110; dwell = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc + 10);
    chk("sc_ch", u_if.out_ch, 1);
    stop = 1'b1;
    repeat (2) @(negedge clk);
    chk("sc_hold_valid", u_if.out_valid, 1);
    chk("sc_hold_ch", u_if.out_ch, 1);
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0; stop = 1'b0;
    chk("sc_done", frame_done, 1);
    chk("sc_valid", u_if.out_valid, 0);
    chk("sc_sel", sel, 0);
    @(negedge clk);
    chk("sc_busy", busy, 0);
    quiet("sc_quiet", 6);

    // asynchronous reset with a sample pending
    tab[2] = 4'hA;
    ch_mask = 6'b000100; dwell = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc + 10);
    chk("rm_pre_valid", u_if.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_valid", u_if.out_valid, 0);
    chk("rm_sel", sel, 0);
    chk("rm_busy", busy, 0);
    chk("rm_data", u_if.out_data, 0);
    chk("rm_ch", u_if.out_ch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("rm_quiet", 4);

`ifdef MUX_SCAN_CONTINUOUS_EN
    begin
      int unsigned a_edge;
      for (int i = 0; i < 8; i++) tab[i] = 4'($urandom);
      @(negedge clk);
      ch_mask = 6'b000011; dwell = 8'd2; start = 1'b1;
      a_edge = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      for (int it = 0; it < 6; it++) begin
        wait_valid(a_edge + 8);
        chk("ct_time", cyc, a_edge + 3);
        chk("ct_ch", u_if.out_ch, it % 2);
        chk("ct_data", u_if.out_data, tab[it % 2]);
        u_if.out_ready = 1'b1;
        a_edge = cyc + 1;
        @(negedge clk);
        u_if.out_ready = 1'b0;
        chk("ct_done", frame_done, (it % 2 == 1) ? 1 : 0);
        chk("ct_busy", busy, 1);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("ct_stop_busy", busy, 0);
      chk("ct_stop_done", frame_done, 0);
      chk("ct_stop_sel", sel, 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
